// File: rtl/reg_bank_pkg.sv
// Shared constants for the MIPS register file, destination mux and control unit.
// Register numbers, destination-select encodings and the $sp reset default live here.
package reg_bank_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_FP   = 30;
    localparam int REG_RA   = 31;

    localparam int SP_RESET_DEFAULT = 227;

    typedef enum logic [2:0] {
        DST_RT = 3'b000,
        DST_RD = 3'b001,
        DST_RA = 3'b010,
        DST_SP = 3'b011,
        DST_FP = 3'b100
    } dst_sel_e;

endpackage

// File: rtl/reg_bank.sv
// 32 x 32-bit MIPS general-purpose register file: one write port, two registered
// read ports with write-first bypass, hardwired $zero and a non-zero $sp reset value.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_RESET = SP_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Register 0 has no storage at all; reads of it are forced to zero below.
    logic [DATA_W-1:0] regs_reg [1:DEPTH-1];
    logic [ADDR_W-1:0] read_addr [2];
    logic [DATA_W-1:0] read_data_reg [2];

    assign read_addr[0] = read_reg1;
    assign read_addr[1] = read_reg2;
    assign read_data1   = read_data_reg[0];
    assign read_data2   = read_data_reg[1];

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_reg[gi] <= (gi == REG_SP) ? DATA_W'(SP_RESET) : '0;
                end else if (reg_write && (write_reg == ADDR_W'(gi))) begin
                    regs_reg[gi] <= write_data;
                end
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_read
            always_ff @(posedge clk) begin
                if (reset) begin
                    read_data_reg[gi] <= '0;
                end else if (read_addr[gi] == ADDR_W'(REG_ZERO)) begin
                    read_data_reg[gi] <= '0;
                end else if (reg_write && (write_reg == read_addr[gi])) begin
                    read_data_reg[gi] <= write_data;
                end else begin
                    read_data_reg[gi] <= regs_reg[read_addr[gi]];
                end
            end
        end
    endgenerate

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 32 x 32-bit MIPS general-purpose register file for the multicycle datapath.
- Write port consumes the destination number produced by the register-destination mux (rt, rd, 31/$ra, 29/$sp or 30/$fp) together with the writeback data.
- Two read ports feed the A/B operand registers.
- Reads are registered (1-cycle latency), with write-first bypass; $zero is hardwired; $sp has a non-zero reset value.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register number width; depth is 2**ADDR_W
- SP_RESET, 227, reset value of register 29 ($sp)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- reg_write  input  1  write enable from the control unit
- write_reg  input  ADDR_W  destination register number (register-destination mux output)
- write_data  input  DATA_W  writeback value
- read_reg1  input  ADDR_W  rs register number
- read_reg2  input  ADDR_W  rt register number
- read_data1  output  DATA_W  registered contents of read_reg1
- read_data2  output  DATA_W  registered contents of read_reg2

Behaviour:
- Reset (synchronous, active-high; takes effect at a rising clk edge with reset=1):
  - all registers become 0 except reg[29], which becomes SP_RESET;
  - read_data1 and read_data2 become 0.
  - Reset has priority over a simultaneous reg_write, which is dropped.
  - A reset asserted mid-sequence discards any pending write; reads resume on the first edge after reset deasserts.
- Write: on a rising edge with reset=0 and reg_write=1, reg[write_reg] <= write_data. If write_reg == 0, the write is discarded and reg[0] stays 0 permanently. reg_write=0 leaves every register unchanged.
- Read:
  - on every rising edge with reset=0, read_dataN <= value(read_regN);
  - value(0) = 0 always;
  - otherwise, if reg_write=1 and write_reg == read_regN, value = write_data (write-first bypass);
  - otherwise value = reg[read_regN].
  - Latency is 1 cycle: read_dataN reflects the addresses and bypass condition sampled at the previous edge. Outputs hold between edges.
- Both ports may address the same register; each bypass is evaluated independently, so both return identical data.
- Addresses are full ADDR_W width. There are no out-of-range cases and no X propagation from unwritten registers, because reset initialises all of them.
- The block does no arithmetic; data is stored unmodified at DATA_W bits.
- Every write takes exactly one cycle. There is no handshake or backpressure; reg_write is a single-cycle strobe from the control FSM.

Decomposition:
- Shared package holds the register-number constants: REG_ZERO=0, REG_SP=29, REG_FP=30, REG_RA=31.
- The same package holds the register-destination selector encodings shared with the destination mux and the control unit: DST_RT=3'b000, DST_RD=3'b001, DST_RA=3'b010, DST_SP=3'b011, DST_FP=3'b100.
- SP_RESET default is also defined in the package.
- No sub-module: storage array plus two identical read-port processes in one module.

Test Plan:
- Reset: hold reset=1 one edge, then read (29, 5) → next edge read_data1=227, read_data2=0. Reset with reg_write=1, write_reg=8, write_data=0xFFFF_FFFF → subsequent read of reg 8 = 0.
- Basic write/read: write reg 8 = 0x1234_5678, next cycle read_reg1=8 → read_data1=0x1234_5678 one edge later. reg_write=0 with write_reg=8, write_data=0 → reg 8 unchanged.
- $zero: write reg 0 = 0xDEAD_BEEF, then read reg 0 on both ports → both 0. Same-cycle write/read of reg 0 → 0, with no bypass.
- Bypass: same edge reg_write=1, write_reg=31, write_data=0x0000_0040, read_reg1=read_reg2=31 → both outputs 0x0000_0040 after that edge, and reg 31 then holds 0x40.
- Destination set: write reg 29 = 0x100, reg 30 = 0x200, reg 31 = 0x300 on consecutive cycles → reads return 0x100/0x200/0x300; all other registers remain at their reset values (spot-check 1, 16, 28).
- Reset mid-operation: write reg 5 = 7, assert reset on the next edge, deassert, read reg 5 → 0; read reg 29 → 227.
